// File: rtl/latch_write_sched.sv
// Round-robin write scheduler for a bank of level-sensitive D latches.
// Each write runs SETUP -> OPEN -> HOLD so lat_d is stable around lat_en.
module latch_write_sched #(
    parameter int NREQ     = 4,
    parameter int W        = 8,
    parameter int OPEN_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] wdata,
    input  logic              clr,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      lat_d,
    output logic              lat_en,
    output logic              lat_rst,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

    localparam logic [2:0] S_CLR   = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_OPEN  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] sel;
    logic [PW-1:0] sel_q;
    logic [PW:0]   sum;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sel_data;
    logic          clr_pend;
    logic          found;
    logic          open_done;

    // Scan from ptr upward with wrap; the first set request wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ))
                sum = sum - (PW+1)'(NREQ);
            if (!found && req[sum[PW-1:0]]) begin
                found = 1'b1;
                sel   = sum[PW-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == PW'(i))
                sel_data = wdata[i*W +: W];
        end
    end

    assign open_done = (cnt == CW'(OPEN_CYC - 1));
    assign ptr_nxt   = (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + PW'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLR:   state_nxt = S_IDLE;
            S_IDLE: begin
                if (clr || clr_pend)
                    state_nxt = S_CLR;
                else if (found)
                    state_nxt = S_SETUP;
            end
            S_SETUP: state_nxt = S_OPEN;
            S_OPEN: begin
                if (open_done)
                    state_nxt = S_HOLD;
            end
            S_HOLD:  state_nxt = S_IDLE;
            default: state_nxt = S_CLR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_CLR;
            ptr      <= '0;
            sel_q    <= '0;
            cnt      <= '0;
            clr_pend <= 1'b0;
            gnt      <= '0;
            ack      <= '0;
            lat_d    <= '0;
            lat_en   <= 1'b0;
            lat_rst  <= 1'b1;
            busy     <= 1'b1;
        end else begin
            state   <= state_nxt;
            lat_en  <= (state_nxt == S_OPEN);
            lat_rst <= (state_nxt == S_CLR);
            busy    <= (state_nxt != S_IDLE);
            ack     <= (state_nxt == S_HOLD) ? gnt : '0;

            // A clear seen in IDLE is taken directly, so pend only collects
            // pulses that arrive while a write or clear is in progress.
            if (state == S_IDLE)
                clr_pend <= 1'b0;
            else if (clr)
                clr_pend <= 1'b1;

            if (state == S_IDLE && state_nxt == S_SETUP) begin
                gnt   <= NREQ'(1) << sel;
                lat_d <= sel_data;
                sel_q <= sel;
            end

            if (state == S_SETUP)
                cnt <= '0;
            else if (state == S_OPEN)
                cnt <= cnt + CW'(1);

            if (state == S_HOLD) begin
                gnt <= '0;
                ptr <= ptr_nxt;
            end
        end
    end

endmodule
